// File: rtl/leaf_stream_packetizer_pkg.sv
// Shared definitions for the BFT transmit packetizer: field layout, sizing, FSM states
// and packet pack/unpack helpers.
package leaf_stream_packetizer_pkg;

  localparam int unsigned PACKET_BITS           = 49;
  localparam int unsigned PAYLOAD_BITS          = 32;
  localparam int unsigned NUM_LEAF_BITS         = 4;
  localparam int unsigned NUM_PORT_BITS         = 4;
  localparam int unsigned NUM_BRAM_ADDR_BITS    = 7;
  localparam int unsigned FREESPACE_UPDATE_SIZE = 64;

  localparam int unsigned CREDIT_BITS  = NUM_BRAM_ADDR_BITS + 1;
  localparam int unsigned INIT_CREDITS = 1 << NUM_BRAM_ADDR_BITS;

  localparam int unsigned VALID_BIT     = 48;
  localparam int unsigned DST_LEAF_MSB  = 47;
  localparam int unsigned DST_LEAF_LSB  = 44;
  localparam int unsigned DST_PORT_MSB  = 43;
  localparam int unsigned DST_PORT_LSB  = 40;
  localparam int unsigned SRC_LEAF_MSB  = 39;
  localparam int unsigned SRC_LEAF_LSB  = 36;
  localparam int unsigned SRC_PORT_MSB  = 35;
  localparam int unsigned SRC_PORT_LSB  = 32;
  localparam int unsigned PAYLOAD_MSB   = 31;
  localparam int unsigned PAYLOAD_LSB   = 0;

  localparam logic [NUM_PORT_BITS-1:0] CTRL_PORT = '0;

  typedef enum logic [1:0] {StIdle, StRun, StStall} tx_state_e;

  typedef logic [PACKET_BITS-1:0] bft_raw_t;

  typedef struct packed {
    logic                     valid;
    logic [NUM_LEAF_BITS-1:0] dst_leaf;
    logic [NUM_PORT_BITS-1:0] dst_port;
    logic [NUM_LEAF_BITS-1:0] src_leaf;
    logic [NUM_PORT_BITS-1:0] src_port;
    logic [PAYLOAD_BITS-1:0]  payload;
  } bft_pkt_t;

  function automatic bft_raw_t pack_pkt(input bft_pkt_t p);
    bft_raw_t r;
    r = '0;
    r[VALID_BIT]                   = p.valid;
    r[DST_LEAF_MSB:DST_LEAF_LSB]   = p.dst_leaf;
    r[DST_PORT_MSB:DST_PORT_LSB]   = p.dst_port;
    r[SRC_LEAF_MSB:SRC_LEAF_LSB]   = p.src_leaf;
    r[SRC_PORT_MSB:SRC_PORT_LSB]   = p.src_port;
    r[PAYLOAD_MSB:PAYLOAD_LSB]     = p.payload;
    return r;
  endfunction

  function automatic bft_pkt_t unpack_pkt(input bft_raw_t r);
    bft_pkt_t p;
    p.valid    = r[VALID_BIT];
    p.dst_leaf = r[DST_LEAF_MSB:DST_LEAF_LSB];
    p.dst_port = r[DST_PORT_MSB:DST_PORT_LSB];
    p.src_leaf = r[SRC_LEAF_MSB:SRC_LEAF_LSB];
    p.src_port = r[SRC_PORT_MSB:SRC_PORT_LSB];
    p.payload  = r[PAYLOAD_MSB:PAYLOAD_LSB];
    return p;
  endfunction

endpackage

// File: rtl/leaf_stream_packetizer_if.sv
// User-stream and BFT-side signals of the packetizer, with environment (master) and
// packetizer (slave) views.
interface leaf_stream_packetizer_if;
  import leaf_stream_packetizer_pkg::*;

  logic [PAYLOAD_BITS-1:0] din_user2tx;
  logic                    vld_user2tx;
  logic                    ack_tx2user;
  logic [PACKET_BITS-1:0]  din_bft2tx;
  logic [PACKET_BITS-1:0]  dout_tx2bft;

  modport master (
    output din_user2tx, vld_user2tx, din_bft2tx,
    input  ack_tx2user, dout_tx2bft
  );

  modport slave (
    input  din_user2tx, vld_user2tx, din_bft2tx,
    output ack_tx2user, dout_tx2bft
  );

endinterface

// File: rtl/leaf_stream_packetizer_credit.sv
// Saturating credit counter for the destination buffer; credit_err latches any overflow
// until reset.
module leaf_credit_counter
  import leaf_stream_packetizer_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   inc_i,
  input  logic                   dec_i,
  output logic [CREDIT_BITS-1:0] credits_o,
  output logic [CREDIT_BITS-1:0] credits_next_o,
  output logic                   credit_err_o
);

  localparam int unsigned SumW = CREDIT_BITS + 1;

  logic [CREDIT_BITS-1:0] credits_q, credits_d;
  logic                   err_q, err_d;
  logic [SumW-1:0]        sum;

  // One spare bit so an update on top of a near-full count is visible before saturation.
  always_comb begin
    sum = {1'b0, credits_q};
    if (inc_i) sum = sum + SumW'(FREESPACE_UPDATE_SIZE);
    if (dec_i) sum = sum - SumW'(1);
    err_d = err_q;
    if (sum > SumW'(INIT_CREDITS)) begin
      credits_d = CREDIT_BITS'(INIT_CREDITS);
      err_d     = 1'b1;
    end else begin
      credits_d = sum[CREDIT_BITS-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credits_q <= CREDIT_BITS'(INIT_CREDITS);
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign credits_o      = credits_q;
  assign credits_next_o = credits_d;
  assign credit_err_o   = err_q;

endmodule

// File: rtl/leaf_stream_packetizer.sv
// Transmit packetizer: wraps accepted user words into BFT packets for one destination and
// throttles acceptance on credits returned by the receiver's freespace updates.
module leaf_stream_packetizer
  import leaf_stream_packetizer_pkg::*;
(
  input  logic                     clk,
  input  logic                     ap_rst_n,
  input  logic                     cfg_en,
  input  logic [NUM_LEAF_BITS-1:0] cfg_src_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_src_port,
  input  logic [NUM_LEAF_BITS-1:0] cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_dst_port,
  leaf_stream_packetizer_if.slave  bus,
  output logic [CREDIT_BITS-1:0]   credits,
  output logic                     credit_err
);

  tx_state_e                state_q, state_d;
  logic [NUM_LEAF_BITS-1:0] dst_leaf_q, dst_leaf_d;
  logic [NUM_PORT_BITS-1:0] dst_port_q, dst_port_d;
  bft_raw_t                 dout_q, dout_d;
  logic [CREDIT_BITS-1:0]   credits_next;
  logic                     ack, xfer, upd;
  bft_pkt_t                 out_pkt;

  assign ack  = (state_q == StRun) && (credits != '0);
  assign xfer = ack && bus.vld_user2tx;

  // Only the paired receiver's control port may hand back credits.
  assign upd = bus.din_bft2tx[VALID_BIT]
            && (bus.din_bft2tx[DST_LEAF_MSB:DST_LEAF_LSB] == cfg_src_leaf)
            && (bus.din_bft2tx[DST_PORT_MSB:DST_PORT_LSB] == CTRL_PORT)
            && (bus.din_bft2tx[SRC_LEAF_MSB:SRC_LEAF_LSB] == dst_leaf_q)
            && (bus.din_bft2tx[SRC_PORT_MSB:SRC_PORT_LSB] == dst_port_q);

  leaf_credit_counter u_credit (
    .clk_i          (clk),
    .rst_ni         (ap_rst_n),
    .inc_i          (upd),
    .dec_i          (xfer),
    .credits_o      (credits),
    .credits_next_o (credits_next),
    .credit_err_o   (credit_err)
  );

  always_comb begin
    state_d    = state_q;
    dst_leaf_d = dst_leaf_q;
    dst_port_d = dst_port_q;
    if (!cfg_en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          dst_leaf_d = cfg_dst_leaf;
          dst_port_d = cfg_dst_port;
          state_d    = StRun;
        end
        StRun:   if (credits_next == '0) state_d = StStall;
        StStall: if (credits != '0) state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    out_pkt          = '0;
    out_pkt.valid    = 1'b1;
    out_pkt.dst_leaf = dst_leaf_q;
    out_pkt.dst_port = dst_port_q;
    out_pkt.src_leaf = cfg_src_leaf;
    out_pkt.src_port = cfg_src_port;
    out_pkt.payload  = bus.din_user2tx;
    dout_d           = xfer ? pack_pkt(out_pkt) : '0;
  end

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= StIdle;
      dst_leaf_q <= '0;
      dst_port_q <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      dst_leaf_q <= dst_leaf_d;
      dst_port_q <= dst_port_d;
      dout_q     <= dout_d;
    end
  end

  assign bus.ack_tx2user = ack;
  assign bus.dout_tx2bft = dout_q;

endmodule

// File: doc/leaf_stream_packetizer.md
Name: leaf_stream_packetizer

Overview:
- Transmit-side packetizer: takes the 32-bit valid/ack user stream from an HLS kernel output and emits 49-bit BFT packets toward one configured destination leaf/port.
- Credit-based flow control: tracks the destination's free BRAM space and consumes freespace-update packets returned over the BFT input.
- Sits between a kernel output and the leaf's BFT output mux; it is the sending end of the receiver's freespace protocol.

Parameters:
- PACKET_BITS, 49, BFT packet width.
- PAYLOAD_BITS, 32, user data width.
- NUM_LEAF_BITS, 4, leaf address width.
- NUM_PORT_BITS, 4, port address width.
- NUM_BRAM_ADDR_BITS, 7, log2 of the destination input buffer depth; initial credits = 2^7 = 128.
- FREESPACE_UPDATE_SIZE, 64, credits granted per freespace-update packet.

Ports:
- clk  in  1  clock.
- ap_rst_n  in  1  reset, asynchronous assert, active-low.
- cfg_en  in  1  level; 1 = stream enabled.
- cfg_src_leaf  in  4  own leaf id, placed in the packet.
- cfg_src_port  in  4  own port id, placed in the packet.
- cfg_dst_leaf  in  4  destination leaf; sampled on the IDLE->RUN transition.
- cfg_dst_port  in  4  destination port; sampled on the IDLE->RUN transition.
- din_user2tx  in  32  user payload.
- vld_user2tx  in  1  user data valid.
- ack_tx2user  out  1  accept; a transfer occurs when vld&ack.
- din_bft2tx  in  49  incoming BFT packets, snooped for freespace updates.
- dout_tx2bft  out  49  outgoing packet; bit 48 = packet valid.
- credits  out  8  current credit count.
- credit_err  out  1  sticky; set on credit overflow.

Behaviour:
- Packet format, used both ways: [48] valid, [47:44] dst_leaf, [43:40] dst_port, [39:36] src_leaf, [35:32] src_port, [31:0] payload.
- Reset values: dout_tx2bft=0, ack_tx2user=0, credits=128, credit_err=0, state=IDLE.
- FSM states:
  - IDLE: ack=0; latch cfg_dst_* when cfg_en=1, then go to RUN.
  - RUN: ack=1 when credits>0; go to STALL when credits reach 0 with no update arriving that cycle.
  - STALL: ack=0; return to RUN on the cycle after credits>0.
  - Any state with cfg_en=0 goes to IDLE. Credits are not reset; in-flight data stays owed.
- ack_tx2user is combinational from the registered state and credits: ack = (state==RUN) && (credits!=0).
- Transfer timing: a transfer in cycle N drives dout_tx2bft in cycle N+1, so latency is 1. When there is no transfer, dout_tx2bft = 0 the next cycle. Throughput is 1 packet/cycle; the BFT output has no backpressure.
- Each transfer decrements credits by 1.
- Freespace update: din_bft2tx[48]=1 && dst_leaf==cfg_src_leaf && dst_port==0 && src_leaf==latched dst_leaf && src_port==latched dst_port.
  - Each update adds FREESPACE_UPDATE_SIZE.
  - Other packets are ignored.
- Same cycle transfer + update: credits += 64-1, giving a net +63.
- Overflow: if the new value would exceed 128, saturate at 128 and set credit_err. credit_err clears only on reset.
- Credits=1 with a transfer and no update: next cycle credits=0, ack=0, state=STALL. No packet is sent with zero credits.
- Width: the credit register is NUM_BRAM_ADDR_BITS+1 bits. Arithmetic uses one extra bit before the saturation compare.
- Reset mid-operation: an asynchronous ap_rst_n low immediately forces all reset values. A packet on dout in that cycle is dropped.

Decomposition:
- Shared package bft_pkg:
  - Field offsets: VALID_BIT=48, DST_LEAF_MSB/LSB, DST_PORT, SRC_LEAF, SRC_PORT, PAYLOAD.
  - CTRL_PORT=0.
  - FSM state typedef {IDLE, RUN, STALL}.
  - Packet pack/unpack functions.
- One natural sub-module: leaf_credit_counter, holding the saturating up/down counter, the update match input, and credit_err.

Test Plan:
- Reset, cfg_en=1, dst=leaf3/port2, src=leaf11/port1; send 0xDEADBEEF -> next cycle dout=1_0011_0010_1011_0001_DEADBEEF, credits=127.
- 128 back-to-back words -> credits=0, ack low in the cycle after the 128th transfer, state STALL, 129th word held with no packet emitted.
- From STALL, inject update packet valid, dst=11/0, src=3/2 -> credits=64, ack returns high, 64 more words accepted.
- At credits=10: transfer and matching update in the same cycle -> credits=73. An update from src=4/2 -> ignored, credits unchanged.
- At credits=100, inject update -> credits=128 (saturated), credit_err=1, and it stays 1 after cfg_en toggles.
- Mid-stream, drop ap_rst_n for 1 cycle asynchronously -> dout=0 and ack=0 immediately; after release, credits=128 and state=IDLE.
